im_boot_loader: RTL and testbench

- Writer side of the instruction-memory write port. Receives a framed program image as a byte stream from the serial receiver and assembles it into 16-bit words.
- Issues one ImWrite pulse per word, with the matching ImWriteAddr/ImWriteData, into the instruction memory (Ram2).
- Holds the CPU stalled from Start until the image is written and its checksum is verified.

---
 rtl/im_boot_loader.sv | 153 +++++++++++++++
 tb/tb_im_boot_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_loader.sv
// Boot loader: receives a framed program image byte-by-byte, assembles 16-bit words,
// writes them into instruction memory and holds the CPU until the checksum is verified.
module im_boot_loader #(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter logic [15:0] MAX_WORDS      = 16'd4096,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        RxValid,
    input  logic [7:0]  RxData,
    output logic        ImWrite,
    output logic [15:0] ImWriteAddr,
    output logic [15:0] ImWriteData,
    output logic        CpuHold,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] WordCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_reg;
    logic [15:0] len_reg;
    logic [7:0]  lo_reg;
    logic [7:0]  csum_reg;
    logic [23:0] tmo_reg;
    logic        im_write_reg;
    logic [15:0] im_write_addr_reg;
    logic [15:0] im_write_data_reg;
    logic        cpu_hold_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        error_reg;
    logic [15:0] word_count_reg;

    logic [15:0] len_next;
    logic [15:0] word_count_next;

    assign len_next        = {RxData, len_reg[7:0]};
    assign word_count_next = word_count_reg + 16'd1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg         <= S_IDLE;
            len_reg           <= '0;
            lo_reg            <= '0;
            csum_reg          <= '0;
            tmo_reg           <= '0;
            im_write_reg      <= 1'b0;
            im_write_addr_reg <= '0;
            im_write_data_reg <= '0;
            cpu_hold_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
            word_count_reg    <= '0;
        end else begin
            im_write_reg <= 1'b0;
            case (state_reg)
                // A byte arriving with Start in an idle state is deliberately dropped.
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start) begin
                        state_reg      <= S_LEN_LO;
                        cpu_hold_reg   <= 1'b1;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        error_reg      <= 1'b0;
                        word_count_reg <= '0;
                        csum_reg       <= '0;
                        tmo_reg        <= '0;
                    end
                end
                default: begin
                    if (RxValid) begin
                        tmo_reg <= '0;
                        case (state_reg)
                            S_LEN_LO: begin
                                len_reg[7:0] <= RxData;
                                state_reg    <= S_LEN_HI;
                            end
                            S_LEN_HI: begin
                                len_reg[15:8] <= RxData;
                                if (len_next > MAX_WORDS) begin
                                    state_reg <= S_ERROR;
                                    error_reg <= 1'b1;
                                    busy_reg  <= 1'b0;
                                end else if (len_next == 16'd0) begin
                                    state_reg <= S_CHECK;
                                end else begin
                                    state_reg <= S_DATA_LO;
                                end
                            end
                            S_DATA_LO: begin
                                lo_reg    <= RxData;
                                csum_reg  <= csum_reg ^ RxData;
                                state_reg <= S_DATA_HI;
                            end
                            S_DATA_HI: begin
                                im_write_data_reg <= {RxData, lo_reg};
                                im_write_addr_reg <= BASE_ADDR + word_count_reg;
                                im_write_reg      <= 1'b1;
                                word_count_reg    <= word_count_next;
                                csum_reg          <= csum_reg ^ RxData;
                                state_reg         <= (word_count_next == len_reg) ? S_CHECK : S_DATA_LO;
                            end
                            S_CHECK: begin
                                busy_reg <= 1'b0;
                                if (RxData == csum_reg) begin
                                    state_reg    <= S_DONE;
                                    done_reg     <= 1'b1;
                                    cpu_hold_reg <= 1'b0;
                                end else begin
                                    state_reg <= S_ERROR;
                                    error_reg <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (tmo_reg >= TIMEOUT_CYCLES - 24'd1) begin
                        // Abort once TIMEOUT_CYCLES consecutive idle cycles have elapsed.
                        state_reg <= S_ERROR;
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        tmo_reg <= tmo_reg + 24'd1;
                    end
                end
            endcase
        end
    end

    assign ImWrite     = im_write_reg;
    assign ImWriteAddr = im_write_addr_reg;
    assign ImWriteData = im_write_data_reg;
    assign CpuHold     = cpu_hold_reg;
    assign Busy        = busy_reg;
    assign Done        = done_reg;
    assign Error       = error_reg;
    assign WordCount   = word_count_reg;

endmodule

// File: tb/tb_im_boot_loader.sv
// Bench for im_boot_loader: two instances (base 0000 and FFFF) share one byte stream
// and are checked against a frame-level model of the loader.
module tb_im_boot_loader;

    localparam logic [23:0] TO = 24'd16;

    logic        Clk = 1'b0;
    logic        Rst, Start, RxValid;
    logic [7:0]  RxData;
    logic        im_write  [2];
    logic [15:0] wr_addr   [2];
    logic [15:0] wr_data   [2];
    logic        cpu_hold  [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];
    logic [15:0] wcount    [2];

    im_boot_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'd4096), .TIMEOUT_CYCLES(TO)) dut0 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .RxValid(RxValid), .RxData(RxData),
        .ImWrite(im_write[0]), .ImWriteAddr(wr_addr[0]), .ImWriteData(wr_data[0]),
        .CpuHold(cpu_hold[0]), .Busy(busy[0]), .Done(done[0]), .Error(err[0]),
        .WordCount(wcount[0])
    );

    im_boot_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(16'd4096), .TIMEOUT_CYCLES(TO)) dut1 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .RxValid(RxValid), .RxData(RxData),
        .ImWrite(im_write[1]), .ImWriteAddr(wr_addr[1]), .ImWriteData(wr_data[1]),
        .CpuHold(cpu_hold[1]), .Busy(busy[1]), .Done(done[1]), .Error(err[1]),
        .WordCount(wcount[1])
    );

    always #5 Clk = ~Clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          pulses [2] = '{0, 0};
    logic [15:0] last_addr [2];
    logic [15:0] last_data [2];
    logic [7:0]  fq [$];

    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++)
            if (im_write[d] === 1'b1) pulses[d]++;
    end

    function automatic logic [15:0] base_of(input int d);
        return (d == 0) ? 16'h0000 : 16'hFFFF;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit e_done, input bit e_err,
                              input bit e_hold, input bit e_busy, input int e_wc);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".done"}, d, 32'(done[d]), 32'(e_done));
            chk({tag, ".error"}, d, 32'(err[d]), 32'(e_err));
            chk({tag, ".hold"}, d, 32'(cpu_hold[d]), 32'(e_hold));
            chk({tag, ".busy"}, d, 32'(busy[d]), 32'(e_busy));
            chk({tag, ".wcount"}, d, 32'(wcount[d]), 32'(e_wc));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".imwrite"}, d, 32'(im_write[d]), 32'd0);
            chk({tag, ".addr"}, d, 32'(wr_addr[d]), 32'd0);
            chk({tag, ".data"}, d, 32'(wr_data[d]), 32'd0);
            last_addr[d] = 16'h0000;
            last_data[d] = 16'h0000;
        end
    endtask

    task automatic do_start(input bit junk);
        @(negedge Clk);
        Start = 1'b1;
        if (junk) begin
            RxValid = 1'b1;
            RxData  = 8'hA5;
        end
        @(negedge Clk);
        Start   = 1'b0;
        RxValid = 1'b0;
        chk_status("start", 1'b0, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        RxValid = 1'b1;
        RxData  = b;
        @(negedge Clk);
        RxValid = 1'b0;
    endtask

    task automatic make_frame(input int n, input bit bad);
        logic [7:0] x, b;
        fq.delete();
        fq.push_back(n[7:0]);
        fq.push_back(n[15:8]);
        x = 8'h00;
        for (int j = 0; j < 2 * n; j++) begin
            b = 8'($urandom);
            x ^= b;
            fq.push_back(b);
        end
        fq.push_back(bad ? ~x : x);
    endtask

    // Frame-level model: words, addresses, checksum and outcome derived from fq alone.
    task automatic run_frame(input int max_gap, input bit junk, input bit mid_start);
        int         n, words, exp_pulses, g, k;
        bit         len_ok, wr, good;
        logic [7:0] x;
        int         p0 [2];
        n          = int'({fq[1], fq[0]});
        len_ok     = (n <= 4096);
        x          = 8'h00;
        words      = 0;
        exp_pulses = 0;
        for (int d = 0; d < 2; d++) p0[d] = pulses[d];
        do_start(junk);
        for (int i = 0; i < fq.size(); i++) begin
            RxValid = 1'b1;
            RxData  = fq[i];
            if (len_ok && i >= 2 && i < 2 + 2 * n) x ^= fq[i];
            @(negedge Clk);
            wr = len_ok && (i >= 3) && ((i - 3) % 2 == 0) && ((i - 3) / 2 < n);
            if (wr) begin
                k = (i - 3) / 2;
                words++;
                exp_pulses++;
                for (int d = 0; d < 2; d++) begin
                    last_addr[d] = base_of(d) + 16'(k);
                    last_data[d] = {fq[i], fq[i-1]};
                end
            end
            for (int d = 0; d < 2; d++) begin
                chk("imwrite", d, 32'(im_write[d]), 32'(wr));
                chk("addr", d, 32'(wr_addr[d]), 32'(last_addr[d]));
                chk("data", d, 32'(wr_data[d]), 32'(last_data[d]));
                chk("wcount", d, 32'(wcount[d]), 32'(words));
                if (i == 1 && !len_ok) chk("len_error", d, 32'(err[d]), 32'd1);
            end
            if (i < fq.size() - 1 && len_ok && max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                if (g > 0) RxValid = 1'b0;
                repeat (g) begin
                    Start = mid_start & 1'($urandom_range(0, 1));
                    @(negedge Clk);
                    Start = 1'b0;
                    for (int d = 0; d < 2; d++) begin
                        chk("gap.imwrite", d, 32'(im_write[d]), 32'd0);
                        chk("gap.addr", d, 32'(wr_addr[d]), 32'(last_addr[d]));
                        chk("gap.data", d, 32'(wr_data[d]), 32'(last_data[d]));
                    end
                end
            end
        end
        RxValid = 1'b0;
        if (!len_ok) begin
            chk_status("badlen", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        end else begin
            good = (fq[fq.size() - 1] == x);
            chk_status("end", good, !good, !good, 1'b0, n);
        end
        @(negedge Clk);
        for (int d = 0; d < 2; d++)
            chk("pulses", d, 32'(pulses[d] - p0[d]), 32'(exp_pulses));
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        chk_reset("reset");

        fq = '{8'h02, 8'h00, 8'h01, 8'h49, 8'h02, 8'h4A, 8'h00};
        run_frame(2, 1'b0, 1'b0);
        $display("tx: good 2-word frame");

        fq = '{8'h02, 8'h00, 8'h01, 8'h49, 8'h02, 8'h4A, 8'hFF};
        run_frame(2, 1'b0, 1'b0);
        $display("tx: 2-word frame with bad checksum");

        fq = '{8'h00, 8'h00, 8'h00};
        run_frame(1, 1'b0, 1'b0);
        $display("tx: empty frame, good checksum");

        fq = '{8'h00, 8'h00, 8'h05};
        run_frame(1, 1'b0, 1'b0);
        $display("tx: empty frame, bad checksum");

        fq = '{8'h01, 8'h10};
        run_frame(0, 1'b0, 1'b0);
        $display("tx: length MAX_WORDS+1 rejected");

        do_start(1'b0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (8) @(negedge Clk);
        chk_status("tmo.early", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        repeat (12) @(negedge Clk);
        chk_status("tmo.late", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        $display("tx: idle timeout aborts load");

        fq = '{8'h02, 8'h00, 8'h01, 8'h49, 8'h02, 8'h4A, 8'h00};
        run_frame(2, 1'b0, 1'b0);
        $display("tx: good frame after timeout");

        fq = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h22};
        run_frame(0, 1'b0, 1'b0);
        $display("tx: back-to-back bytes, address wrap on base FFFF");

        do_start(1'b0);
        foreach (fq[i]) if (i < 5) begin
            RxValid = 1'b1;
            RxData  = fq[i];
            @(negedge Clk);
        end
        RxValid = 1'b0;
        Rst     = 1'b1;
        @(negedge Clk);
        Rst     = 1'b0;
        chk_reset("midrst");
        $display("tx: reset mid-frame");

        fq = '{8'h02, 8'h00, 8'h01, 8'h49, 8'h02, 8'h4A, 8'h00};
        run_frame(1, 1'b1, 1'b0);
        $display("tx: good frame after reset, junk byte with Start");

        for (int t = 0; t < 8; t++) begin
            int  n;
            bit  bad;
            n   = $urandom_range(0, 6);
            bad = 1'($urandom_range(0, 1));
            make_frame(n, bad);
            run_frame(3, 1'($urandom_range(0, 1)), 1'b1);
            $display("tx: random frame %0d, %0d words, checksum %s", t, n, bad ? "bad" : "good");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
